// File: rtl/ram_arb_defs_pkg.sv
// Shared definitions for the RAM port arbiter: FSM state encoding and
// width helpers for counters and requester indices.
package ram_arb_defs;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = value - 1;
    while (span > 0) begin
      result++;
      span = span >> 1;
    end
    return result;
  endfunction

  // A field must hold at least one bit even when only a single value exists.
  function automatic int width_for(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin search: first requester at or after 'start',
// wrapping around, skipping anything set in 'exclude'.
module rr_priority_select
  import ram_arb_defs::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = width_for(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  input  logic [NUM_REQ-1:0] exclude,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   index,
  output logic               any_valid
);

  logic [NUM_REQ-1:0] cand;

  assign cand = req & ~exclude;

  always_comb begin
    winner    = '0;
    index     = '0;
    any_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_valid && cand[(int'(start) + k) % NUM_REQ]) begin
        any_valid                                 = 1'b1;
        index                                     = IDX_W'((int'(start) + k) % NUM_REQ);
        winner[(int'(start) + k) % NUM_REQ]       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among NUM_REQ requesters,
// with burst-capped tenure and tagged one-cycle read return.
module ram_port_arbiter
  import ram_arb_defs::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int addr_width = 8,
  parameter int data_width = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clock,
  input  logic                          clear,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*addr_width-1:0] req_addr,
  input  logic [NUM_REQ*data_width-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rd_valid,
  output logic [data_width-1:0]         rd_data,
  output logic [addr_width-1:0]         ram_addr,
  output logic [data_width-1:0]         ram_data,
  output logic                          ram_we,
  input  logic [data_width-1:0]         ram_out
);

  localparam int IDX_W = width_for(NUM_REQ);
  localparam int CNT_W = width_for(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_t         state, state_next;
  logic [IDX_W-1:0]   owner, owner_next;
  logic [IDX_W-1:0]   rr_ptr, rr_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [NUM_REQ-1:0] gnt_next;

  logic [IDX_W-1:0]   sel_start;
  logic [NUM_REQ-1:0] sel_exclude;
  logic [NUM_REQ-1:0] sel_winner;
  logic [IDX_W-1:0]   sel_index;
  logic               sel_any;
  logic               transfer;
  logic               take;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // From idle the search resumes at rr_ptr; while owning, it starts just past
  // the owner and excludes it, so a handoff always goes to someone else.
  assign sel_start   = (state == ST_IDLE) ? rr_ptr : next_idx(owner);
  assign sel_exclude = (state == ST_IDLE) ? '0 : gnt;

  rr_priority_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_select (
    .req       (req),
    .start     (sel_start),
    .exclude   (sel_exclude),
    .winner    (sel_winner),
    .index     (sel_index),
    .any_valid (sel_any)
  );

  assign transfer = (state == ST_OWN) && req[owner];
  assign rd_data  = ram_out;

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_data = '0;
    if (transfer) begin
      ram_we   = req_we[owner];
      ram_addr = req_addr[int'(owner)*addr_width +: addr_width];
      ram_data = req_data[int'(owner)*data_width +: data_width];
    end
  end

  always_comb begin
    state_next = state;
    owner_next = owner;
    gnt_next   = gnt;
    cnt_next   = cnt;
    rr_next    = rr_ptr;
    take       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sel_any) take = 1'b1;
      end
      ST_OWN: begin
        if (!req[owner]) begin
          if (sel_any) begin
            take = 1'b1;
          end else begin
            state_next = ST_IDLE;
            gnt_next   = '0;
            cnt_next   = '0;
          end
        end else if (cnt == CNT_LAST) begin
          // A lone requester at its burst limit simply starts a fresh burst.
          if (sel_any) take = 1'b1;
          else         cnt_next = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (take) begin
      state_next = ST_OWN;
      owner_next = sel_index;
      gnt_next   = sel_winner;
      cnt_next   = '0;
      rr_next    = next_idx(sel_index);
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state    <= ST_IDLE;
      owner    <= '0;
      gnt      <= '0;
      cnt      <= '0;
      rr_ptr   <= '0;
      rd_valid <= '0;
    end else begin
      state    <= state_next;
      owner    <= owner_next;
      gnt      <= gnt_next;
      cnt      <= cnt_next;
      rr_ptr   <= rr_next;
      rd_valid <= (transfer && !req_we[owner]) ? gnt : '0;
    end
  end

endmodule
